// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
// Shared definitions for the up/down guessing game.
//   state_t   : guess-entry FSM states (IDLE, ARM, FIRE, WAIT_RELEASE)
//   DIGIT_MAX : largest BCD digit value before wrap
//   GUESS_W   : width of the binary guess (0..99)
//   BCD_W     : width of one BCD digit
// -----------------------------------------------------------------------------
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ARM          = 2'd1,
    FIRE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int DIGIT_MAX = 9;
  localparam int GUESS_W   = 7;
  localparam int BCD_W     = 4;

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions one raw asynchronous push-button: 2-FF synchronizer, stability
// counter, debounced level and a one-cycle rising-edge press pulse.
//   clk, reset : system clock, synchronous active-high reset
//   btn_raw    : raw asynchronous button input (active-high)
//   level      : debounced button level
//   press      : one-cycle pulse on a rising edge of level
// Raw edge (held stable) to press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      // stage p0/p1: metastability synchronizer
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      // debounce: count cycles in which the synchronized level disagrees with
      // the debounced one; any agreement (a bounce) restarts the count
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // edge detect: press lands one cycle after the level rises
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/guess_entry.sv
// -----------------------------------------------------------------------------
// guess_entry
// Button front end for the up/down guessing game: builds a two-digit decimal
// guess from tens/ones/clear buttons and issues a clean one-cycle strobe when
// enter is pressed.
//   clk, reset    : system clock, synchronous active-high reset
//   btn_tens      : raw button, increments tens digit (9 wraps to 0)
//   btn_ones      : raw button, increments ones digit (9 wraps to 0, no carry)
//   btn_clear     : raw button, zeroes both digits (wins over tens/ones)
//   btn_enter     : raw button, submits the guess
//   lock          : synchronous; discards every button event while high
//   tens_digit    : current tens digit (BCD)
//   ones_digit    : current ones digit (BCD)
//   user_input    : registered tens*10+ones, one cycle behind the digits
//   guess_trigger : one-cycle strobe, user_input stable while high
// Optional feature macro: GUESS_AUTO_REPEAT_EN adds hold-to-repeat on the
// tens/ones buttons (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
// -----------------------------------------------------------------------------
module guess_entry
  import updown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_tens,
  input  logic               btn_ones,
  input  logic               btn_clear,
  input  logic               btn_enter,
  input  logic               lock,
  output logic [BCD_W-1:0]   tens_digit,
  output logic [BCD_W-1:0]   ones_digit,
  output logic [GUESS_W-1:0] user_input,
  output logic               guess_trigger
);

  function automatic logic [BCD_W-1:0] digit_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(DIGIT_MAX)) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [GUESS_W-1:0] to_bin(input logic [BCD_W-1:0] t,
                                                input logic [BCD_W-1:0] o);
    return GUESS_W'(t) * GUESS_W'(10) + GUESS_W'(o);
  endfunction

  logic tens_level, ones_level, clear_level, enter_level;
  logic tens_press, ones_press, clear_press, enter_press;
  logic tens_inc, ones_inc;
  logic edit_en;

  state_t             state;
  logic               fire_q;
  logic [BCD_W-1:0]   tens_p0;
  logic [BCD_W-1:0]   ones_p0;
  logic [GUESS_W-1:0] bin_p1;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tens (
    .clk(clk), .reset(reset), .btn_raw(btn_tens), .level(tens_level), .press(tens_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ones (
    .clk(clk), .reset(reset), .btn_raw(btn_ones), .level(ones_level), .press(ones_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .reset(reset), .btn_raw(btn_clear), .level(clear_level), .press(clear_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .reset(reset), .btn_raw(btn_enter), .level(enter_level), .press(enter_press)
  );

`ifdef GUESS_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [1:0]       rep_level;
  logic [1:0]       rep_started;
  logic [1:0]       rep_pulse;
  logic [REP_W-1:0] rep_cnt [2];

  // index 0 = tens, index 1 = ones
  assign rep_level = {ones_level, tens_level};

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_started <= '0;
      rep_pulse   <= '0;
      rep_cnt[0]  <= '0;
      rep_cnt[1]  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_pulse[i] <= 1'b0;
        if (!rep_level[i]) begin
          rep_cnt[i]     <= '0;
          rep_started[i] <= 1'b0;
        end else if (!rep_started[i] && rep_cnt[i] == REP_W'(REPEAT_DELAY - 1)) begin
          rep_cnt[i]     <= '0;
          rep_started[i] <= 1'b1;
          rep_pulse[i]   <= 1'b1;
        end else if (rep_started[i] && rep_cnt[i] == REP_W'(REPEAT_PERIOD - 1)) begin
          rep_cnt[i]   <= '0;
          rep_pulse[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tens_inc = tens_press | rep_pulse[0];
  assign ones_inc = ones_press | rep_pulse[1];

  logic unused_levels;
  assign unused_levels = clear_level;
`else
  assign tens_inc = tens_press;
  assign ones_inc = ones_press;

  // Edit-button levels only matter to auto-repeat.
  logic unused_levels;
  assign unused_levels = ^{tens_level, ones_level, clear_level};
`endif

  // Digits are frozen outside IDLE and on the cycle enter is accepted.
  assign edit_en = (state == IDLE) && !lock && !enter_press;

  // stage p0: digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_p0 <= '0;
      ones_p0 <= '0;
    end else if (edit_en) begin
      if (clear_press) begin
        tens_p0 <= '0;
        ones_p0 <= '0;
      end else begin
        if (tens_inc) tens_p0 <= digit_inc(tens_p0);
        if (ones_inc) ones_p0 <= digit_inc(ones_p0);
      end
    end
  end

  // stage p1: binary guess
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_p1 <= '0;
    end else begin
      bin_p1 <= to_bin(tens_p0, ones_p0);
    end
  end

  // submit FSM; ARM gives bin_p1 one cycle to catch up with the frozen digits
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      fire_q <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enter_press && !lock) state <= ARM;
        end
        ARM: begin
          if (lock) begin
            state <= WAIT_RELEASE;
          end else begin
            state  <= FIRE;
            fire_q <= 1'b1;
          end
        end
        FIRE: begin
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!enter_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tens_digit    = tens_p0;
  assign ones_digit    = ones_p0;
  assign user_input    = bin_p1;
  // lock raised during FIRE still suppresses the strobe
  assign guess_trigger = fire_q & ~lock;

endmodule
